// File: rtl/key_click_decoder_pkg.sv
// ---------------------------------------------------------------------------
// key_click_pkg
//   Shared definitions for the key click gesture decoder:
//   - 3-bit FSM state encodings (plain localparams so older tools that
//     dislike enums in ports/casez still accept them)
//   - default interval counts for a ~5 MHz..50 MHz class system clock
//   - packed struct bundling the four gesture pulse outputs
// ---------------------------------------------------------------------------
package key_click_pkg;

    // FSM state encoding
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_PRESS1   = 3'd1;
    localparam logic [2:0] ST_HOLD     = 3'd2;
    localparam logic [2:0] ST_GAP      = 3'd3;
    localparam logic [2:0] ST_WAIT_REL = 3'd4;

    // Default parameter values
    localparam int DEF_CNT_WIDTH  = 24;
    localparam int DEF_LONG_CNT   = 5000000;
    localparam int DEF_DBL_CNT    = 2500000;
    localparam int DEF_REPEAT_CNT = 1000000;

    // Gesture pulses; at most one field is set in any cycle
    typedef struct packed {
        logic click;
        logic dbl;
        logic long_press;
        logic rpt;
    } kc_pulse_t;

endpackage

// File: rtl/key_click_decoder_if.sv
// ---------------------------------------------------------------------------
// key_click_decoder_if
//   Bundles the gesture decoder's event inputs and pulse outputs so a
//   producer (debouncer side) and consumer (decoder side) can be wired as
//   one object.
//   master : drives press_i/release_i, observes the gesture pulses
//   slave  : the decoder view (consumes press/release, drives pulses)
// ---------------------------------------------------------------------------
interface key_click_decoder_if;

    logic press_i;
    logic release_i;
    logic click_o;
    logic dbl_o;
    logic long_o;
    logic repeat_o;
    logic busy_o;

    modport master (
        output press_i,
        output release_i,
        input  click_o,
        input  dbl_o,
        input  long_o,
        input  repeat_o,
        input  busy_o
    );

    modport slave (
        input  press_i,
        input  release_i,
        output click_o,
        output dbl_o,
        output long_o,
        output repeat_o,
        output busy_o
    );

endinterface

// File: rtl/key_click_decoder.sv
// ---------------------------------------------------------------------------
// key_click_decoder
//   Classifies clean press/release pulses from a switch debouncer into
//   gestures: single click, double click, long press and auto-repeat while
//   held. One FSM plus one shared interval counter; all outputs are
//   registered one-cycle pulses.
//
// Ports
//   clk_i      in  system clock
//   rst_n_i    in  asynchronous reset, active low
//   press_i    in  1-cycle pulse: switch became pressed
//   release_i  in  1-cycle pulse: switch became released
//   click_o    out pulse: single short click confirmed
//   dbl_o      out pulse: double click
//   long_o     out pulse: long-press threshold reached
//   repeat_o   out pulse: auto-repeat tick while held after long_o
//   busy_o     out high whenever the FSM is not idle
// ---------------------------------------------------------------------------
module key_click_decoder
    import key_click_pkg::*;
#(
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
    parameter int LONG_CNT   = DEF_LONG_CNT,
    parameter int DBL_CNT    = DEF_DBL_CNT,
    parameter int REPEAT_CNT = DEF_REPEAT_CNT
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic press_i,
    input  logic release_i,
    output logic click_o,
    output logic dbl_o,
    output logic long_o,
    output logic repeat_o,
    output logic busy_o
);

    // Elaboration-time parameter sanity checks
    localparam longint CNT_LIMIT = longint'(1) << CNT_WIDTH;

    if (LONG_CNT < 2 || longint'(LONG_CNT) >= CNT_LIMIT) begin : g_bad_long
        $error("key_click_decoder: LONG_CNT out of range");
    end
    if (DBL_CNT < 2 || longint'(DBL_CNT) >= CNT_LIMIT) begin : g_bad_dbl
        $error("key_click_decoder: DBL_CNT out of range");
    end
    if (REPEAT_CNT < 2 || longint'(REPEAT_CNT) >= CNT_LIMIT) begin : g_bad_rpt
        $error("key_click_decoder: REPEAT_CNT out of range");
    end

    // Terminal counter values: the transition fires on the edge where the
    // counter already holds *_CNT-1, i.e. *_CNT edges after state entry.
    localparam logic [CNT_WIDTH-1:0] LONG_LAST = CNT_WIDTH'(LONG_CNT - 1);
    localparam logic [CNT_WIDTH-1:0] DBL_LAST  = CNT_WIDTH'(DBL_CNT - 1);
    localparam logic [CNT_WIDTH-1:0] RPT_LAST  = CNT_WIDTH'(REPEAT_CNT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

    logic [2:0]           state_d, state_q;
    logic [CNT_WIDTH-1:0] cnt_d, cnt_q;
    kc_pulse_t            pulse_d, pulse_q;
    logic                 busy_d, busy_q;

    // Simultaneous press and release is a protocol violation; both are
    // treated as absent while the counter keeps running.
    logic press_only, release_only;
    assign press_only   = press_i & ~release_i;
    assign release_only = release_i & ~press_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        pulse_d = '0;

        case (state_q)
            ST_IDLE: begin
                // Counter is parked at zero so it cannot wrap while idle
                cnt_d = '0;
                if (press_only) begin
                    state_d = ST_PRESS1;
                end
            end

            ST_PRESS1: begin
                // Release takes priority over a coincident long timeout
                if (release_only) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                end else if (cnt_q == LONG_LAST) begin
                    state_d            = ST_HOLD;
                    cnt_d              = '0;
                    pulse_d.long_press = 1'b1;
                end
            end

            ST_HOLD: begin
                if (release_only) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == RPT_LAST) begin
                    cnt_d       = '0;
                    pulse_d.rpt = 1'b1;
                end
            end

            ST_GAP: begin
                // Second press takes priority over a coincident gap timeout
                if (press_only) begin
                    state_d     = ST_WAIT_REL;
                    cnt_d       = '0;
                    pulse_d.dbl = 1'b1;
                end else if (cnt_q == DBL_LAST) begin
                    state_d       = ST_IDLE;
                    cnt_d         = '0;
                    pulse_d.click = 1'b1;
                end
            end

            ST_WAIT_REL: begin
                // No timeout here, so hold the counter at full scale rather
                // than let a very long second press wrap it.
                if (release_only) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    cnt_d = cnt_q;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pulse_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            busy_q  <= busy_d;
        end
    end

    assign click_o  = pulse_q.click;
    assign dbl_o    = pulse_q.dbl;
    assign long_o   = pulse_q.long_press;
    assign repeat_o = pulse_q.rpt;
    assign busy_o   = busy_q;

endmodule

// File: tb/tb_key_click_decoder.sv
// ---------------------------------------------------------------------------
// tb_key_click_decoder
//   Directed-vector bench for key_click_decoder with LONG_CNT=8, DBL_CNT=4,
//   REPEAT_CNT=3. A negedge monitor records count and edge number of every
//   output pulse; expected edge numbers are derived by hand from the press
//   and release edges each test applies.
// ---------------------------------------------------------------------------
module tb_key_click_decoder;

    logic clk;
    logic rst_n;
    int   cyc;

    key_click_decoder_if u_if ();

    key_click_decoder #(
        .CNT_WIDTH  (8),
        .LONG_CNT   (8),
        .DBL_CNT    (4),
        .REPEAT_CNT (3)
    ) u_dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .press_i   (u_if.press_i),
        .release_i (u_if.release_i),
        .click_o   (u_if.click_o),
        .dbl_o     (u_if.dbl_o),
        .long_o    (u_if.long_o),
        .repeat_o  (u_if.repeat_o),
        .busy_o    (u_if.busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter: after rising edge E, cyc == E
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor
    int click_cnt, dbl_cnt, long_cnt, rpt_cnt, multi_cnt;
    int click_cyc, dbl_cyc, long_cyc, rpt_first, rpt_last;

    always @(negedge clk) begin
        if ((int'(u_if.click_o) + int'(u_if.dbl_o) + int'(u_if.long_o)
             + int'(u_if.repeat_o)) > 1)
            multi_cnt++;
        if (u_if.click_o === 1'b1) begin click_cnt++; click_cyc = cyc; end
        if (u_if.dbl_o   === 1'b1) begin dbl_cnt++;   dbl_cyc   = cyc; end
        if (u_if.long_o  === 1'b1) begin long_cnt++;  long_cyc  = cyc; end
        if (u_if.repeat_o === 1'b1) begin
            if (rpt_cnt == 0) rpt_first = cyc;
            rpt_cnt++;
            rpt_last = cyc;
        end
    end

    int nvec, nerr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic clr();
        click_cnt = 0; dbl_cnt = 0; long_cnt = 0; rpt_cnt = 0;
        click_cyc = -1; dbl_cyc = -1; long_cyc = -1; rpt_first = -1; rpt_last = -1;
    endtask

    // Called at a negedge: drive inputs for exactly one rising edge.
    // Returns the edge number that samples them; returns at the negedge after it.
    task automatic drive(input logic p, input logic r, output int e);
        u_if.press_i   = p;
        u_if.release_i = r;
        e = cyc + 1;
        @(negedge clk);
        u_if.press_i   = 1'b0;
        u_if.release_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    int m, n, p, e;

    initial begin
        nvec = 0; nerr = 0; multi_cnt = 0;
        clr();
        rst_n          = 1'b0;
        u_if.press_i   = 1'b0;
        u_if.release_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", u_if.busy_o, 0);
        chk("reset_pulses", {u_if.click_o, u_if.dbl_o, u_if.long_o, u_if.repeat_o}, 0);
        rst_n = 1'b1;
        idle(2);

        // Reset in the middle of PRESS1 with cnt=5
        clr();
        drive(1'b1, 1'b0, m);
        idle(5);
        chk("mid_busy", u_if.busy_o, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_busy", u_if.busy_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(12);
        chk("rst_drop", click_cnt + dbl_cnt + long_cnt + rpt_cnt, 0);
        // fresh press after reset: counter restarts from zero
        clr();
        drive(1'b1, 1'b0, p);
        idle(9);
        chk("fresh_long_cnt", long_cnt, 1);
        chk("fresh_long_cyc", long_cyc, p + 8);
        drive(1'b0, 1'b1, e);
        idle(2);
        chk("fresh_idle", u_if.busy_o, 0);

        // Single click: release 3 cycles after press
        clr();
        drive(1'b1, 1'b0, m);
        idle(2);
        drive(1'b0, 1'b1, n);
        idle(6);
        chk("click_cnt", click_cnt, 1);
        chk("click_cyc", click_cyc, n + 4);
        chk("click_no_dbl_long", dbl_cnt + long_cnt, 0);
        chk("click_busy", u_if.busy_o, 0);

        // Double click: second press 2 cycles after release
        clr();
        drive(1'b1, 1'b0, m);
        drive(1'b0, 1'b1, n);
        idle(1);
        drive(1'b1, 1'b0, p);
        idle(1);
        chk("dbl_cnt", dbl_cnt, 1);
        chk("dbl_cyc", dbl_cyc, n + 2);
        chk("dbl_wait_busy", u_if.busy_o, 1);
        drive(1'b0, 1'b1, e);
        idle(6);
        chk("dbl_no_click", click_cnt, 0);
        chk("dbl_busy", u_if.busy_o, 0);

        // Long press held 15 cycles with auto-repeat
        clr();
        drive(1'b1, 1'b0, m);
        idle(14);
        drive(1'b0, 1'b1, e);
        idle(8);
        chk("long_cnt", long_cnt, 1);
        chk("long_cyc", long_cyc, m + 8);
        chk("rpt_cnt", rpt_cnt, 2);
        chk("rpt_first", rpt_first, m + 11);
        chk("rpt_last", rpt_last, m + 14);
        chk("long_no_click", click_cnt + dbl_cnt, 0);
        chk("long_busy", u_if.busy_o, 0);

        // Release on the long-timeout edge: release wins
        clr();
        drive(1'b1, 1'b0, m);
        idle(7);
        drive(1'b0, 1'b1, n);
        idle(6);
        chk("edge_rel_no_long", long_cnt, 0);
        chk("edge_rel_click", click_cnt, 1);
        chk("edge_rel_click_cyc", click_cyc, m + 12);

        // Press on the gap-timeout edge: press wins
        clr();
        drive(1'b1, 1'b0, m);
        drive(1'b0, 1'b1, n);
        idle(3);
        drive(1'b1, 1'b0, p);
        idle(1);
        chk("edge_prs_dbl", dbl_cnt, 1);
        chk("edge_prs_dbl_cyc", dbl_cyc, n + 4);
        drive(1'b0, 1'b1, e);
        idle(6);
        chk("edge_prs_no_click", click_cnt, 0);

        // Extra press while in PRESS1 is ignored (no restart of the interval)
        clr();
        drive(1'b1, 1'b0, m);
        idle(1);
        drive(1'b1, 1'b0, e);
        drive(1'b0, 1'b1, n);
        idle(6);
        chk("ign_press_click_cyc", click_cyc, m + 7);
        chk("ign_press_dbl", dbl_cnt, 0);

        // press_i and release_i together in IDLE: ignored
        clr();
        drive(1'b1, 1'b1, e);
        chk("both_busy_now", u_if.busy_o, 0);
        idle(10);
        chk("both_no_pulse", click_cnt + dbl_cnt + long_cnt + rpt_cnt, 0);
        chk("both_busy", u_if.busy_o, 0);

        chk("one_pulse_per_cycle", multi_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
